// File: rtl/test_controller.sv
// Test-run sequencer: holds the CPU in reset, releases it, and judges the run
// by watching for a tohost store, a stuck program counter, or a cycle timeout.
module test_controller #(
   parameter int unsigned HOLD_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50,
   parameter int unsigned STALL_LIMIT    = 8,
   parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] pc,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_write,
   input  logic        mem_we,
   output logic        cpu_rst_n,
   output logic        done,
   output logic        pass,
   output logic [1:0]  fail_code,
   output logic [31:0] result,
   output logic [31:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_RUN,
      S_PASS,
      S_FAIL
   } state_t;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_RESULT  = 2'd1;
   localparam logic [1:0] FC_HANG    = 2'd2;
   localparam logic [1:0] FC_TIMEOUT = 2'd3;

   state_t      state_q, state_d;
   logic [7:0]  hold_q, hold_d;
   logic [7:0]  stall_q, stall_d;
   logic [31:0] prev_pc_q, prev_pc_d;
   logic        first_q, first_d;
   logic [1:0]  fail_code_q, fail_code_d;
   logic [31:0] result_q, result_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        tohost_store;

   assign tohost_store = mem_we && (mem_address == TOHOST_ADDR);

   // Next-state, counter and registered-output logic
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      stall_d       = stall_q;
      prev_pc_d     = prev_pc_q;
      first_d       = first_q;
      fail_code_d   = fail_code_q;
      result_d      = result_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         S_IDLE, S_PASS, S_FAIL: begin
            if (start) begin
               state_d       = S_HOLD;
               hold_d        = 8'(HOLD_CYCLES);
               stall_d       = '0;
               cycle_count_d = '0;
               result_d      = '0;
               fail_code_d   = FC_NONE;
               first_d       = 1'b1;
            end
         end
         S_HOLD: begin
            hold_d = hold_q - 8'd1;
            if (hold_q == 8'd1) state_d = S_RUN;
         end
         S_RUN: begin
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
            first_d   = 1'b0;
            prev_pc_d = pc;
            // No previous pc exists in the first RUN cycle
            if (first_q || (pc != prev_pc_q)) stall_d = '0;
            else                              stall_d = stall_q + 8'd1;

            if (tohost_store) begin
               result_d = mem_write;
               if (mem_write == 32'd1) begin
                  state_d = S_PASS;
               end else begin
                  state_d     = S_FAIL;
                  fail_code_d = FC_RESULT;
               end
            end else if (stall_d == 8'(STALL_LIMIT)) begin
               state_d     = S_FAIL;
               fail_code_d = FC_HANG;
            end else if (cycle_count_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_d     = S_FAIL;
               fail_code_d = FC_TIMEOUT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cpu_rst_n_d = (state_d == S_RUN);
      done_d      = (state_d == S_PASS) || (state_d == S_FAIL);
      pass_d      = (state_d == S_PASS);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         hold_q        <= '0;
         stall_q       <= '0;
         prev_pc_q     <= '0;
         first_q       <= 1'b0;
         fail_code_q   <= '0;
         result_q      <= '0;
         cycle_count_q <= '0;
         cpu_rst_n_q   <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         stall_q       <= stall_d;
         prev_pc_q     <= prev_pc_d;
         first_q       <= first_d;
         fail_code_q   <= fail_code_d;
         result_q      <= result_d;
         cycle_count_q <= cycle_count_d;
         cpu_rst_n_q   <= cpu_rst_n_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
      end
   end

   assign cpu_rst_n   = cpu_rst_n_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_code   = fail_code_q;
   assign result      = result_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_test_controller.sv
// Randomized self-checking bench for test_controller against a run-level model.
module tb_test_controller;

   localparam int unsigned HOLD    = 2;
   localparam int unsigned TIMEOUT = 50;
   localparam int unsigned STALL   = 8;
   localparam logic [31:0] TOHOST  = 32'h0000_0FFC;
   localparam int          DEPTH   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] mem_address = '0;
   logic [31:0] mem_write = '0;
   logic        mem_we = 1'b0;
   logic        cpu_rst_n, done, pass;
   logic [1:0]  fail_code;
   logic [31:0] result, cycle_count;

   int n_checks = 0;
   int n_errors = 0;

   // Per-RUN-cycle stimulus for one test run
   logic [31:0] s_pc[DEPTH];
   logic        s_we[DEPTH];
   logic [31:0] s_addr[DEPTH];
   logic [31:0] s_data[DEPTH];
   logic        s_start[DEPTH];

   // Expected outcome of the run
   logic        exp_pass;
   logic [1:0]  exp_code;
   logic [31:0] exp_result;
   int          exp_cc;

   test_controller #(
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TIMEOUT),
      .STALL_LIMIT   (STALL),
      .TOHOST_ADDR   (TOHOST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pc         (pc),
      .mem_address(mem_address),
      .mem_write  (mem_write),
      .mem_we     (mem_we),
      .cpu_rst_n  (cpu_rst_n),
      .done       (done),
      .pass       (pass),
      .fail_code  (fail_code),
      .result     (result),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Outcome from the rules: first cycle with a tohost store, a pc repeated
   // STALL times in a row, or the last cycle allowed before timeout.
   task automatic model_run();
      int stall = 0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k > 0 && s_pc[k] == s_pc[k-1]) stall++;
         else stall = 0;
         if (s_we[k] && s_addr[k] == TOHOST) begin
            exp_result = s_data[k];
            exp_pass   = (s_data[k] == 32'd1);
            exp_code   = exp_pass ? 2'd0 : 2'd1;
            exp_cc     = k + 1;
            return;
         end
         if (stall == STALL) begin
            exp_result = '0; exp_pass = 1'b0; exp_code = 2'd2; exp_cc = k + 1;
            return;
         end
         if (k == TIMEOUT - 1) begin
            exp_result = '0; exp_pass = 1'b0; exp_code = 2'd3; exp_cc = k + 1;
            return;
         end
      end
   endtask

   task automatic gen_base(input bit const_pc);
      for (int i = 0; i < DEPTH; i++) begin
         s_pc[i]    = const_pc ? 32'h40 : 32'h100 + 32'(4 * i);
         s_we[i]    = 1'b0;
         s_addr[i]  = '0;
         s_data[i]  = '0;
         s_start[i] = 1'b0;
      end
   endtask

   task automatic gen_random();
      logic [31:0] cur;
      int rep = 0;
      int sk;
      cur = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < DEPTH; i++) begin
         if (i > 0) begin
            if (rep > 0) rep--;
            else begin
               cur = cur + 32'd4;
               if ($urandom_range(0, 7) == 0) rep = int'($urandom_range(4, 12));
            end
         end
         s_pc[i]    = cur;
         s_we[i]    = ($urandom_range(0, 3) == 0);
         s_addr[i]  = $urandom;
         if (s_addr[i] == TOHOST) s_addr[i] = s_addr[i] ^ 32'h4;
         s_data[i]  = $urandom;
         s_start[i] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 1) == 1) begin
         sk = int'($urandom_range(0, DEPTH - 1));
         s_we[sk]   = 1'b1;
         s_addr[sk] = TOHOST;
         s_data[sk] = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      end
   endtask

   // Pulse start (with a tohost store that must be ignored outside RUN),
   // check HOLD-entry clearing and the CPU reset length.
   task automatic start_run(input string name);
      int lows = 0;
      @(negedge clk);
      start = 1'b1; mem_we = 1'b1; mem_address = TOHOST; mem_write = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, ".hold_result"}, result, '0);
      check({name, ".hold_cc"}, cycle_count, '0);
      check({name, ".hold_done"}, {31'd0, done}, '0);
      check({name, ".hold_pass"}, {31'd0, pass}, '0);
      check({name, ".hold_code"}, {30'd0, fail_code}, '0);
      while (!cpu_rst_n && lows < 20) begin
         lows++;
         @(posedge clk); #1;
      end
      check({name, ".hold_len"}, lows, HOLD);
   endtask

   task automatic finish_run(input string name);
      int k = 0;
      bit bad_run = 1'b0;
      while (!done && k < DEPTH) begin
         if (!cpu_rst_n) bad_run = 1'b1;
         pc = s_pc[k]; mem_we = s_we[k]; mem_address = s_addr[k];
         mem_write = s_data[k]; start = s_start[k];
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0; mem_we = 1'b0;
      check({name, ".run_rstn"}, {31'd0, bad_run}, '0);
      check({name, ".done"}, {31'd0, done}, 32'd1);
      check({name, ".end_cycle"}, k, exp_cc);
      check({name, ".pass"}, {31'd0, pass}, {31'd0, exp_pass});
      check({name, ".code"}, {30'd0, fail_code}, {30'd0, exp_code});
      check({name, ".result"}, result, exp_result);
      check({name, ".cc"}, cycle_count, exp_cc);
      check({name, ".cpu_rstn"}, {31'd0, cpu_rst_n}, '0);
      // Outcome must stay frozen while idle in the final state
      repeat (3) begin
         pc = pc + 32'd4;
         @(posedge clk); #1;
      end
      check({name, ".sticky_done"}, {31'd0, done}, 32'd1);
      check({name, ".sticky_cc"}, cycle_count, exp_cc);
   endtask

   task automatic do_run(input string name);
      model_run();
      start_run(name);
      finish_run(name);
   endtask

   initial begin
      #2;
      check("rst.cpu_rstn", {31'd0, cpu_rst_n}, '0);
      check("rst.done", {31'd0, done}, '0);
      check("rst.cc", cycle_count, '0);
      check("rst.result", result, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle.cpu_rstn", {31'd0, cpu_rst_n}, '0);
      check("idle.done", {31'd0, done}, '0);

      // Pass at RUN cycle 10, with an ignored write to a neighbour address
      gen_base(1'b0);
      s_we[3] = 1'b1; s_addr[3] = 32'h0000_0FF8; s_data[3] = 32'd1;
      s_we[10] = 1'b1; s_addr[10] = TOHOST; s_data[10] = 32'd1;
      do_run("pass10");

      // Restart from PASS into a bad-result run
      gen_base(1'b0);
      s_we[10] = 1'b1; s_addr[10] = TOHOST; s_data[10] = 32'h5;
      do_run("bad5");

      gen_base(1'b1);
      do_run("hang");

      gen_base(1'b1);
      s_we[8] = 1'b1; s_addr[8] = TOHOST; s_data[8] = 32'd1;
      do_run("hang_vs_store");

      gen_base(1'b0);
      do_run("timeout");

      // Asynchronous abort in the middle of RUN
      start_run("abort");
      for (int i = 0; i < 5; i++) begin
         pc = 32'h200 + 32'(4 * i);
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("abort.cpu_rstn", {31'd0, cpu_rst_n}, '0);
      check("abort.cc", cycle_count, '0);
      check("abort.done", {31'd0, done}, '0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort.idle", {31'd0, cpu_rst_n}, '0);

      gen_base(1'b0);
      s_we[6] = 1'b1; s_addr[6] = 32'h0000_0FF8; s_data[6] = 32'd7;
      s_we[20] = 1'b1; s_addr[20] = TOHOST; s_data[20] = 32'd1;
      do_run("after_abort");

      for (int r = 0; r < 30; r++) begin
         gen_random();
         do_run($sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
